// File: rtl/axis_rx_arbiter_pkg.sv
// Shared types and constants for the dataplane rx arbiter.
package dataplane_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    XFER
  } arb_state_e;

  localparam int MAX_SRC = 8;
  localparam int CNT_W   = 32;

endpackage

// File: rtl/axis_rx_arbiter_if.sv
// AXI-Stream bundle; N lanes share one bundle, lane i owns data bits [i*DW +: DW].
interface axis_rx_arbiter_if #(
  parameter int N  = 1,
  parameter int DW = 64
);

  logic [N-1:0]      tvalid;
  logic [N*DW-1:0]   tdata;
  logic [N*DW/8-1:0] tkeep;
  logic [N-1:0]      tlast;
  logic [N-1:0]      tready;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_rx_arbiter_rr_grant_sel.sv
// Combinational round-robin picker: first enabled requester after the last grant, wrapping.
module rr_grant_sel
  import dataplane_arb_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int IDW     = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] en_i,
  input  logic [IDW-1:0]     lastGrant_i,
  output logic [IDW-1:0]     grant_o,
  output logic               valid_o
);

  logic [NUM_SRC-1:0] maskedReq;
  int                 idx;
  logic               found;

  assign maskedReq = req_i & en_i;

  // Search starts one past the previous winner so the last winner ranks lowest.
  always_comb begin
    grant_o = lastGrant_i;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(lastGrant_i) + k) % NUM_SRC;
      if (!found && maskedReq[idx]) begin
        found   = 1'b1;
        grant_o = IDW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/axis_rx_arbiter.sv
// Packet-granular round-robin arbiter onto the dataplane rx stream.
// Optional ARB_PKT_CNT_EN adds per-source accepted-packet counters on pkt_cnt_o.
module axis_rx_arbiter
  import dataplane_arb_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 64,
  localparam int IDW        = $clog2(NUM_SRC),
  localparam int KW         = DATA_WIDTH / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_en_i,
  axis_rx_arbiter_if.slave   s_axis,
  axis_rx_arbiter_if.master  m_axis,
  output logic [IDW-1:0]     grant_id_o,
  output logic               busy_o
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [NUM_SRC*CNT_W-1:0] pkt_cnt_o
`endif
);

  arb_state_e            state_q;
  logic [IDW-1:0]        grantId_q;
  logic                  mValid_q, mValid_d;
  logic [DATA_WIDTH-1:0] mData_q, mData_d;
  logic [KW-1:0]         mKeep_q, mKeep_d;
  logic                  mLast_q, mLast_d;

  logic [IDW-1:0]        selGrant;
  logic                  selValid;
  logic                  srcReady;
  logic                  accept;
  logic                  beatLast;
  logic [DATA_WIDTH-1:0] beatData;
  logic [KW-1:0]         beatKeep;

  rr_grant_sel #(
    .NUM_SRC(NUM_SRC)
  ) u_sel (
    .req_i      (s_axis.tvalid),
    .en_i       (src_en_i),
    .lastGrant_i(grantId_q),
    .grant_o    (selGrant),
    .valid_o    (selValid)
  );

  assign srcReady = !mValid_q || m_axis.tready[0];
  assign accept   = (state_q == XFER) && s_axis.tvalid[grantId_q] && srcReady;
  assign beatLast = s_axis.tlast[grantId_q];
  assign beatData = s_axis.tdata[grantId_q*DATA_WIDTH +: DATA_WIDTH];
  assign beatKeep = s_axis.tkeep[grantId_q*KW +: KW];

  always_comb begin
    s_axis.tready = '0;
    if (state_q == XFER) begin
      s_axis.tready[grantId_q] = srcReady;
    end
  end

  // Load and drain in the same cycle keeps m_tvalid high for back-to-back beats.
  always_comb begin
    mValid_d = mValid_q;
    mData_d  = mData_q;
    mKeep_d  = mKeep_q;
    mLast_d  = mLast_q;
    if (accept) begin
      mValid_d = 1'b1;
      mData_d  = beatData;
      mKeep_d  = beatKeep;
      mLast_d  = beatLast;
    end else if (m_axis.tready[0]) begin
      mValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grantId_q <= IDW'(NUM_SRC - 1);
      mValid_q  <= 1'b0;
      mData_q   <= '0;
      mKeep_q   <= '0;
      mLast_q   <= 1'b0;
    end else begin
      mValid_q <= mValid_d;
      mData_q  <= mData_d;
      mKeep_q  <= mKeep_d;
      mLast_q  <= mLast_d;
      case (state_q)
        IDLE: begin
          if (selValid) begin
            grantId_q <= selGrant;
            state_q   <= XFER;
          end
        end
        XFER: begin
          if (accept && beatLast) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign m_axis.tvalid = mValid_q;
  assign m_axis.tdata  = mData_q;
  assign m_axis.tkeep  = mKeep_q;
  assign m_axis.tlast  = mLast_q;
  assign grant_id_o    = grantId_q;
  assign busy_o        = (state_q == XFER);

`ifdef ARB_PKT_CNT_EN
  logic [NUM_SRC-1:0][CNT_W-1:0] pktCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pktCnt_q <= '0;
    end else if (accept && beatLast) begin
      pktCnt_q[grantId_q] <= pktCnt_q[grantId_q] + 1'b1;
    end
  end

  assign pkt_cnt_o = pktCnt_q;
`endif

endmodule

// File: tb/tb_axis_rx_arbiter.sv
// Directed bench for axis_rx_arbiter; define ARB_PKT_CNT_EN to also cover the packet counters.
module tb_axis_rx_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] srcEn;
  logic [1:0] grantId;
  logic       busy;
`ifdef ARB_PKT_CNT_EN
  logic [NS*32-1:0] pktCnt;
`endif

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  axis_rx_arbiter_if #(.N(NS), .DW(DW)) sIf ();
  axis_rx_arbiter_if #(.N(1),  .DW(DW)) mIf ();

  axis_rx_arbiter #(
    .NUM_SRC   (NS),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_en_i  (srcEn),
    .s_axis    (sIf),
    .m_axis    (mIf),
    .grant_id_o(grantId),
    .busy_o    (busy)
`ifdef ARB_PKT_CNT_EN
    ,
    .pkt_cnt_o (pktCnt)
`endif
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [7:0]  beat;
    logic        mReady;
    logic [3:0]  expSReady;
    logic        expMValid;
    logic [63:0] expMData;
    logic        expMLast;
    logic [7:0]  expMKeep;
    logic [1:0]  expGrant;
    logic        expBusy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [3:0] valid, logic [3:0] last, logic [7:0] beat, logic mReady,
                              logic [3:0] sr, logic mv, logic [63:0] md, logic ml, logic [7:0] mk8,
                              logic [1:0] g, logic b);
    vec_t v;
    v.valid = valid; v.last = last; v.beat = beat; v.mReady = mReady;
    v.expSReady = sr; v.expMValid = mv; v.expMData = md; v.expMLast = ml;
    v.expMKeep = mk8; v.expGrant = g; v.expBusy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Lane i carries {i, beat} with keep 0xFF>>i so the granted source is visible in the output.
  task automatic driveLanes(input logic [3:0] valid, input logic [3:0] last, input logic [7:0] beat);
    sIf.tvalid = valid;
    sIf.tlast  = last;
    for (int i = 0; i < NS; i++) begin
      sIf.tdata[i*DW +: DW] = (64'(i) << 32) | 64'(beat);
      sIf.tkeep[i*8 +: 8]   = 8'hFF >> i;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    driveLanes(v.valid, v.last, v.beat);
    mIf.tready = v.mReady;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("vec%0d s_tready", idx), 64'(sIf.tready), 64'(v.expSReady));
    check($sformatf("vec%0d m_tvalid", idx), 64'(mIf.tvalid), 64'(v.expMValid));
    check($sformatf("vec%0d grant_id", idx), 64'(grantId), 64'(v.expGrant));
    check($sformatf("vec%0d busy", idx), 64'(busy), 64'(v.expBusy));
    if (v.expMValid) begin
      check($sformatf("vec%0d m_tdata", idx), mIf.tdata, v.expMData);
      check($sformatf("vec%0d m_tlast", idx), 64'(mIf.tlast), 64'(v.expMLast));
      check($sformatf("vec%0d m_tkeep", idx), 64'(mIf.tkeep), 64'(v.expMKeep));
    end
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    srcEn = 4'hF;
    mIf.tready = 1'b1;
    driveLanes(4'h0, 4'h0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every source offers single-beat packets continuously; order holds five 2-bit grants, first at LSB.
  task automatic runRotation(input string tag, input logic [3:0] en, input logic [9:0] order);
    logic [1:0] g;
    srcEn = en;
    mIf.tready = 1'b1;
    driveLanes(4'hF, 4'hF, 8'h07);
    for (int k = 0; k < 5; k++) begin
      g = order[k*2 +: 2];
      @(posedge clk);
      #1;
      check($sformatf("%s pkt%0d grant_id", tag, k), 64'(grantId), 64'(g));
      check($sformatf("%s pkt%0d busy", tag, k), 64'(busy), 64'd1);
      check($sformatf("%s pkt%0d s_tready", tag, k), 64'(sIf.tready), 64'(4'b0001 << g));
      @(posedge clk);
      #1;
      check($sformatf("%s pkt%0d gap busy", tag, k), 64'(busy), 64'd0);
      check($sformatf("%s pkt%0d gap s_tready", tag, k), 64'(sIf.tready), 64'd0);
      check($sformatf("%s pkt%0d m_tvalid", tag, k), 64'(mIf.tvalid), 64'd1);
      check($sformatf("%s pkt%0d m_tdata", tag, k), mIf.tdata, (64'(g) << 32) | 64'h7);
    end
  endtask

  initial begin
    // Src0 three-beat packet, downstream always ready.
    vecs[0]  = mk(4'b0001, 4'b0000, 8'd1, 1'b1, 4'b0000, 1'b0, 64'h0, 1'b0, 8'h00, 2'd3, 1'b0);
    vecs[1]  = mk(4'b0001, 4'b0000, 8'd1, 1'b1, 4'b0001, 1'b0, 64'h0, 1'b0, 8'h00, 2'd0, 1'b1);
    vecs[2]  = mk(4'b0001, 4'b0000, 8'd2, 1'b1, 4'b0001, 1'b1, 64'h1, 1'b0, 8'hFF, 2'd0, 1'b1);
    vecs[3]  = mk(4'b0001, 4'b0001, 8'd3, 1'b1, 4'b0001, 1'b1, 64'h2, 1'b0, 8'hFF, 2'd0, 1'b1);
    vecs[4]  = mk(4'b0000, 4'b0000, 8'd3, 1'b1, 4'b0000, 1'b1, 64'h3, 1'b1, 8'hFF, 2'd0, 1'b0);
    vecs[5]  = mk(4'b0000, 4'b0000, 8'd3, 1'b1, 4'b0000, 1'b0, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    // Src1 four-beat packet with m_tready 1,0,0,1 while src2 waits with a single-beat packet.
    vecs[6]  = mk(4'b0110, 4'b0100, 8'd1, 1'b1, 4'b0000, 1'b0, 64'h0, 1'b0, 8'h00, 2'd3, 1'b0);
    vecs[7]  = mk(4'b0110, 4'b0100, 8'd1, 1'b1, 4'b0010, 1'b0, 64'h0, 1'b0, 8'h00, 2'd1, 1'b1);
    vecs[8]  = mk(4'b0110, 4'b0100, 8'd2, 1'b1, 4'b0010, 1'b1, 64'h1_0000_0001, 1'b0, 8'h7F, 2'd1, 1'b1);
    vecs[9]  = mk(4'b0110, 4'b0100, 8'd3, 1'b0, 4'b0000, 1'b1, 64'h1_0000_0002, 1'b0, 8'h7F, 2'd1, 1'b1);
    vecs[10] = mk(4'b0110, 4'b0100, 8'd3, 1'b0, 4'b0000, 1'b1, 64'h1_0000_0002, 1'b0, 8'h7F, 2'd1, 1'b1);
    vecs[11] = mk(4'b0110, 4'b0100, 8'd3, 1'b1, 4'b0010, 1'b1, 64'h1_0000_0002, 1'b0, 8'h7F, 2'd1, 1'b1);
    vecs[12] = mk(4'b0110, 4'b0110, 8'd4, 1'b1, 4'b0010, 1'b1, 64'h1_0000_0003, 1'b0, 8'h7F, 2'd1, 1'b1);
    vecs[13] = mk(4'b0100, 4'b0100, 8'd5, 1'b1, 4'b0000, 1'b1, 64'h1_0000_0004, 1'b1, 8'h7F, 2'd1, 1'b0);
    vecs[14] = mk(4'b0100, 4'b0100, 8'd5, 1'b1, 4'b0100, 1'b0, 64'h0, 1'b0, 8'h00, 2'd2, 1'b1);
    vecs[15] = mk(4'b0000, 4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 64'h2_0000_0005, 1'b1, 8'h3F, 2'd2, 1'b0);

    applyReset();
    check("reset m_tvalid", 64'(mIf.tvalid), 64'd0);
    check("reset m_tdata", mIf.tdata, 64'd0);
    check("reset m_tkeep", 64'(mIf.tkeep), 64'd0);
    check("reset m_tlast", 64'(mIf.tlast), 64'd0);
    check("reset s_tready", 64'(sIf.tready), 64'd0);
    check("reset grant_id", 64'(grantId), 64'd3);
    check("reset busy", 64'(busy), 64'd0);

    runVectors(0, 5);
    applyReset();
    runVectors(6, 15);

    applyReset();
    runRotation("rr_all", 4'b1111, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
    applyReset();
    runRotation("rr_en1010", 4'b1010, {2'd1, 2'd3, 2'd1, 2'd3, 2'd1});

    // Reset lands while beat 2 of a five-beat src2 packet is on offer.
    applyReset();
    driveLanes(4'b0100, 4'b0000, 8'd1);
    @(posedge clk);
    #1;
    check("midrst grant_id before", 64'(grantId), 64'd2);
    @(posedge clk);
    #1;
    check("midrst m_tvalid before", 64'(mIf.tvalid), 64'd1);
    driveLanes(4'b0100, 4'b0000, 8'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst m_tvalid", 64'(mIf.tvalid), 64'd0);
    check("midrst s_tready", 64'(sIf.tready), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst grant_id", 64'(grantId), 64'd3);
    rst = 1'b0;
    driveLanes(4'b0101, 4'b0101, 8'd9);
    @(posedge clk);
    #1;
    check("postrst grant_id", 64'(grantId), 64'd0);
    check("postrst busy", 64'(busy), 64'd1);
    check("postrst m_tvalid", 64'(mIf.tvalid), 64'd0);

`ifdef ARB_PKT_CNT_EN
    applyReset();
    check("cnt reset", pktCnt, '0);
    driveLanes(4'b0100, 4'b0100, 8'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    driveLanes(4'b0000, 4'b0000, 8'd0);
    @(posedge clk);
    #1;
    driveLanes(4'b0001, 4'b0001, 8'd2);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    driveLanes(4'b0000, 4'b0000, 8'd0);
    @(posedge clk);
    #1;
    check("pkt_cnt[0]", 64'(pktCnt[0*32 +: 32]), 64'd1);
    check("pkt_cnt[1]", 64'(pktCnt[1*32 +: 32]), 64'd0);
    check("pkt_cnt[2]", 64'(pktCnt[2*32 +: 32]), 64'd3);
    check("pkt_cnt[3]", 64'(pktCnt[3*32 +: 32]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
